// File: rtl/sar_oversampler.sv
// sar_oversampler: soc/eoc toggle sequencer summing 2**OSR_LOG2 sar codes per valid/ready result
// Optional eoc watchdog is built in when SAR_SEQ_TIMEOUT_EN is defined.
module sar_oversampler #(
    parameter int NBIT     = 10,
    parameter int OSR_LOG2 = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                     f100m_clk,
    input  logic                     rstb,
    input  logic                     en,
    input  logic                     clr,
    output logic                     sar_soc,
    input  logic                     sar_eoc,
    input  logic [NBIT-1:0]          sar_code,
    output logic [NBIT+OSR_LOG2-1:0] res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     ovr,
    output logic                     err
);
    localparam int AW = NBIT + OSR_LOG2;
    localparam int CW = OSR_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          eoc_q, eoc_edge, last, tmo;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    assign eoc_edge = sar_eoc ^ eoc_q;
    assign last     = cnt == CW'((1 << OSR_LOG2) - 1);

`ifdef SAR_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmr;

    assign tmo = state == WAIT && !eoc_edge && tmr == TW'(TIMEOUT - 1);

    always_ff @(posedge f100m_clk or negedge rstb) begin
        if (!rstb) begin
            tmr <= '0;
            err <= 1'b0;
        end else begin
            tmr <= state == WAIT ? tmr + 1'b1 : '0;
            err <= tmo | (err & ~clr);
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge f100m_clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? REQ : IDLE;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = eoc_edge ? (last ? DONE : REQ) : (tmo ? IDLE : WAIT);
            DONE:    state_nxt = en ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge f100m_clk or negedge rstb) begin
        if (!rstb) begin
            eoc_q     <= 1'b0;
            sar_soc   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            eoc_q <= sar_eoc;
            if (state == REQ) sar_soc <= ~sar_soc;
            if (state == WAIT && eoc_edge) begin
                acc <= acc + AW'(sar_code);
                cnt <= cnt + 1'b1;
            end
            if (state == DONE || tmo) begin
                acc <= '0;
                cnt <= '0;
            end
            if (state == DONE) begin
                res_data  <= acc;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            // an unconsumed result replaced by a new one is the only overrun
            ovr <= (state == DONE && res_valid && !res_ready) | (ovr & ~clr);
        end
    end
endmodule

// File: tb/tb_sar_oversampler.sv
// tb_sar_oversampler: directed checks of sar_oversampler against a toggle-handshake sar model.
// Timeout checks are compiled in when SAR_SEQ_TIMEOUT_EN is defined.
module tb_sar_oversampler;
    logic        f100m_clk = 1'b0;
    logic        rstb = 1'b0, en = 1'b0, clr = 1'b0, sar_eoc = 1'b0, res_ready = 1'b0;
    logic [9:0]  sar_code = '0;
    logic        sar_soc, res_valid, ovr, err;
    logic [11:0] res_data;
    int          errors = 0, checks = 0, soc_cnt = 0, eoc_cnt = 0, lat = 3, b = 0, be = 0;
    logic        answer = 1'b0, kick = 1'b0, soc_seen = 1'b0, p;
    logic [9:0]  code_q[$];

    always #5 f100m_clk = ~f100m_clk;

    sar_oversampler dut (
        .f100m_clk(f100m_clk), .rstb(rstb), .en(en), .clr(clr),
        .sar_soc(sar_soc), .sar_eoc(sar_eoc), .sar_code(sar_code),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .ovr(ovr), .err(err)
    );

    task chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task step;
        @(posedge f100m_clk);
        #1;
    endtask

    // sar model: answers each soc edge after lat cycles with the next queued code
    initial begin
        forever begin
            step();
            if (kick) begin
                sar_code = 10'h100;
                sar_eoc  = 1'b1;
                kick     = 1'b0;
            end
            if (!rstb) begin
                soc_seen = 1'b0;
            end else if (sar_soc != soc_seen) begin
                soc_seen = sar_soc;
                soc_cnt++;
                if (answer) begin
                    repeat (lat) step();
                    sar_code = code_q.size() > 0 ? code_q.pop_front() : 10'h0;
                    sar_eoc  = ~sar_eoc;
                    eoc_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_soc", sar_soc, 0);
        chk("rst_data", res_data, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_err", err, 0);
        rstb = 1'b1;
        step();

        lat = 40;
        answer = 1'b1;
        repeat (4) code_q.push_back(10'h3FF);
        b = soc_cnt;
        en = 1'b1;
        step();
        chk("t1_lat1", sar_soc, 0);
        step();
        chk("t1_lat2", sar_soc, 1);
        for (int i = 0; i < 2000 && soc_cnt < b + 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 2000 && !res_valid; i++) step();
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 12'hFFC);
        chk("t1_ovr", ovr, 0);
        repeat (60) step();
        chk("t1_socs", soc_cnt - b, 4);
        chk("t1_hold", res_data, 12'hFFC);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("t1_pop", res_valid, 0);

        lat = 3;
        for (int i = 1; i <= 4; i++) code_q.push_back(10'(i));
        res_ready = 1'b1;
        b = soc_cnt;
        be = eoc_cnt;
        en = 1'b1;
        for (int i = 0; i < 2000 && eoc_cnt < be + 2; i++) step();
        en = 1'b0;
        for (int i = 0; i < 2000 && !res_valid; i++) step();
        chk("t2_valid", res_valid, 1);
        chk("t2_data", res_data, 12'd10);
        chk("t2_ovr", ovr, 0);
        step();
        chk("t2_1cyc", res_valid, 0);
        repeat (40) step();
        chk("t2_socs", soc_cnt - b, 4);
        chk("t2_eocs", eoc_cnt - be, 4);
        res_ready = 1'b0;

        repeat (4) code_q.push_back(10'd5);
        repeat (4) code_q.push_back(10'd7);
        b = soc_cnt;
        be = eoc_cnt;
        en = 1'b1;
        for (int i = 0; i < 2000 && eoc_cnt < be + 6; i++) step();
        en = 1'b0;
        chk("t3_valid1", res_valid, 1);
        chk("t3_data1", res_data, 12'd20);
        chk("t3_ovr0", ovr, 0);
        for (int i = 0; i < 2000 && !ovr; i++) step();
        chk("t3_ovr1", ovr, 1);
        chk("t3_data2", res_data, 12'd28);
        chk("t3_valid2", res_valid, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t3_clr", ovr, 0);
        chk("t3_keep", res_valid, 1);
        repeat (30) step();
        chk("t3_socs", soc_cnt - b, 8);

`ifdef SAR_SEQ_TIMEOUT_EN
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        code_q.push_back(10'h3FF);
        be = eoc_cnt;
        en = 1'b1;
        for (int i = 0; i < 2000 && eoc_cnt < be + 1; i++) step();
        answer = 1'b0;
        p = sar_soc;
        for (int i = 0; i < 20 && sar_soc == p; i++) step();
        en = 1'b0;
        repeat (254) step();
        chk("t4_pre", err, 0);
        step();
        chk("t4_err", err, 1);
        b = soc_cnt;
        repeat (20) step();
        chk("t4_idle", soc_cnt - b, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr", err, 0);
        answer = 1'b1;
        repeat (4) code_q.push_back(10'd1);
        b = soc_cnt;
        en = 1'b1;
        for (int i = 0; i < 2000 && soc_cnt < b + 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 2000 && !res_valid; i++) step();
        chk("t4_data", res_data, 12'd4);
`else
        chk("t4_err0", err, 0);
`endif

        answer = 1'b0;
        en = 1'b1;
        p = sar_soc;
        for (int i = 0; i < 20 && sar_soc == p; i++) step();
        step();
        step();
        rstb = 1'b0;
        #2;
        chk("t5_soc", sar_soc, 0);
        chk("t5_data", res_data, 0);
        chk("t5_valid", res_valid, 0);
        chk("t5_ovr", ovr, 0);
        chk("t5_err", err, 0);
        kick = 1'b1;
        step();
        step();
        answer = 1'b1;
        lat = 3;
        repeat (4) code_q.push_back(10'd2);
        b = soc_cnt;
        rstb = 1'b1;
        for (int i = 0; i < 2000 && soc_cnt < b + 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 2000 && !res_valid; i++) step();
        chk("t5_rdata", res_data, 12'd8);
        repeat (30) step();
        chk("t5_socs", soc_cnt - b, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
